// File: rtl/rv32i_pkg.sv
// Shared RV32I constants: the opcodes and load funct3 codes the writeback stage decodes.
package rv32i_pkg;

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/rv32i_regfile.sv
// Architectural register file: one write port, two combinational read ports.
// x0 always reads zero; a read of the register being written this cycle
// returns the incoming value so decode never sees a stale operand.
module rv32i_regfile #(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);

    logic [NREGS-1:0][31:0] regs;

    // Storage: clear everything on reset, never write x0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            regs <= '0;
        else if (we && waddr != 5'd0)
            regs[waddr] <= wdata;
    end

    // Read ports with x0 forcing and write-through bypass.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != 5'd0)
            rdata1 = (we && raddr1 == waddr) ? wdata : regs[raddr1];
        if (raddr2 != 5'd0)
            rdata2 = (we && raddr2 == waddr) ? wdata : regs[raddr2];
    end

endmodule

// File: rtl/rv32i_wb_stage.sv
// RV32I writeback stage: picks and aligns the writeback value, detects
// misaligned/illegal loads, commits into the owned register file and keeps
// the retired-instruction and load-fault counters.
module rv32i_wb_stage
    import rv32i_pkg::*;
#(
    parameter int NREGS     = 32,
    parameter int INSTRET_W = 64,
    parameter int FCNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wb_en_in,
    input  logic [31:0]          pc_in,
    input  logic [31:0]          iw_in,
    input  logic [31:0]          alu_in,
    input  logic [4:0]           wb_reg_in,
    input  logic [31:0]          dmem_rdata_in,
    input  logic [4:0]           rd_addr1_in,
    input  logic [4:0]           rd_addr2_in,
    output logic [31:0]          rs1_data_out,
    output logic [31:0]          rs2_data_out,
    output logic                 wb_en_out,
    output logic [4:0]           wb_reg_out,
    output logic [31:0]          wb_data_out,
    output logic                 load_fault_out,
    output logic [FCNT_W-1:0]    fault_cnt_out,
    output logic [INSTRET_W-1:0] instret_out
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [1:0]  off;
    logic        is_load;
    logic        bubble;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] wb_val;
    logic        fault;
    logic        commit;

    assign opcode  = iw_in[6:0];
    assign funct3  = iw_in[14:12];
    assign off     = alu_in[1:0];
    assign is_load = (opcode == OP_LOAD);
    assign bubble  = (iw_in == 32'h0);

    // Byte/halfword lane select out of the aligned memory word.
    always_comb begin
        ld_byte = dmem_rdata_in[7:0];
        case (off)
            2'd0: ld_byte = dmem_rdata_in[7:0];
            2'd1: ld_byte = dmem_rdata_in[15:8];
            2'd2: ld_byte = dmem_rdata_in[23:16];
            2'd3: ld_byte = dmem_rdata_in[31:24];
            default: ld_byte = dmem_rdata_in[7:0];
        endcase
        ld_half = off[1] ? dmem_rdata_in[31:16] : dmem_rdata_in[15:0];
    end

    // Sign/zero extension by load width; illegal widths are caught as faults.
    always_comb begin
        case (funct3)
            F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_data = {24'd0, ld_byte};
            F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            F3_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = dmem_rdata_in;
        endcase
    end

    // Misaligned halfword/word or reserved load width; wb_en_in does not gate this.
    always_comb begin
        fault = 1'b0;
        if (is_load) begin
            case (funct3)
                F3_LH, F3_LHU: fault = off[0];
                F3_LW:         fault = (off != 2'd0);
                F3_LB, F3_LBU: fault = 1'b0;
                default:       fault = 1'b1;
            endcase
        end
    end

    // Writeback value: load data, link address, or ALU result.
    always_comb begin
        case (opcode)
            OP_LOAD:         wb_val = ld_data;
            OP_JAL, OP_JALR: wb_val = pc_in + 32'd4;
            default:         wb_val = alu_in;
        endcase
    end

    assign commit = wb_en_in && (wb_reg_in != 5'd0) && !fault;

    rv32i_regfile #(.NREGS(NREGS)) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (commit),
        .waddr  (wb_reg_in),
        .wdata  (wb_val),
        .raddr1 (rd_addr1_in),
        .raddr2 (rd_addr2_in),
        .rdata1 (rs1_data_out),
        .rdata2 (rs2_data_out)
    );

    // Registered view of the write just committed, for forwarding into decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_en_out      <= 1'b0;
            wb_reg_out     <= 5'd0;
            wb_data_out    <= 32'd0;
            load_fault_out <= 1'b0;
        end else begin
            wb_en_out      <= commit;
            wb_reg_out     <= wb_reg_in;
            wb_data_out    <= wb_val;
            load_fault_out <= fault;
        end
    end

    // Saturating fault counter and wrapping retired-instruction counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_cnt_out <= '0;
            instret_out   <= '0;
        end else begin
            if (fault && fault_cnt_out != {FCNT_W{1'b1}})
                fault_cnt_out <= fault_cnt_out + FCNT_W'(1);
            if (!bubble)
                instret_out <= instret_out + INSTRET_W'(1);
        end
    end

endmodule

// File: tb/tb_rv32i_wb_stage.sv
// Directed bench for rv32i_wb_stage: a vector table for value selection,
// alignment and faults, plus hand sequences for reset, bypass, fault
// saturation and instret wrap. INSTRET_W is reduced so the wrap is reachable.
module tb_rv32i_wb_stage;
    import rv32i_pkg::*;

    localparam int NREGS     = 32;
    localparam int INSTRET_W = 10;
    localparam int FCNT_W    = 8;
    localparam logic [6:0] OP_ALU = 7'b0110011;
    localparam logic [31:0] DMEM  = 32'h80FF7F01;

    logic                 clk;
    logic                 reset;
    logic                 wb_en_in;
    logic [31:0]          pc_in, iw_in, alu_in, dmem_rdata_in;
    logic [4:0]           wb_reg_in, rd_addr1_in, rd_addr2_in;
    logic [31:0]          rs1_data_out, rs2_data_out, wb_data_out;
    logic                 wb_en_out, load_fault_out;
    logic [4:0]           wb_reg_out;
    logic [FCNT_W-1:0]    fault_cnt_out;
    logic [INSTRET_W-1:0] instret_out;

    rv32i_wb_stage #(.NREGS(NREGS), .INSTRET_W(INSTRET_W), .FCNT_W(FCNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .wb_en_in       (wb_en_in),
        .pc_in          (pc_in),
        .iw_in          (iw_in),
        .alu_in         (alu_in),
        .wb_reg_in      (wb_reg_in),
        .dmem_rdata_in  (dmem_rdata_in),
        .rd_addr1_in    (rd_addr1_in),
        .rd_addr2_in    (rd_addr2_in),
        .rs1_data_out   (rs1_data_out),
        .rs2_data_out   (rs2_data_out),
        .wb_en_out      (wb_en_out),
        .wb_reg_out     (wb_reg_out),
        .wb_data_out    (wb_data_out),
        .load_fault_out (load_fault_out),
        .fault_cnt_out  (fault_cnt_out),
        .instret_out    (instret_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] iw;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        en;
        logic        exp_en;
        logic [31:0] exp_data;
        logic        exp_fault;
        logic        chk_data;
    } vec_t;

    localparam int NV = 16;
    vec_t vt [NV];

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
        return {17'd0, f3, 5'd0, op};
    endfunction

    function automatic vec_t v(input logic [31:0] iw, input logic [31:0] pc,
                               input logic [31:0] alu, input logic [4:0] rd,
                               input logic en, input logic exp_en,
                               input logic [31:0] exp_data, input logic exp_fault,
                               input logic chk_data);
        vec_t r;
        r.iw = iw; r.pc = pc; r.alu = alu; r.rd = rd; r.en = en;
        r.exp_en = exp_en; r.exp_data = exp_data; r.exp_fault = exp_fault;
        r.chk_data = chk_data;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] iw, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [4:0] rd, input logic en);
        iw_in = iw; pc_in = pc; alu_in = alu; wb_reg_in = rd; wb_en_in = en;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        logic [FCNT_W-1:0]    m_fcnt;
        logic [INSTRET_W-1:0] m_ret;

        reset = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        dmem_rdata_in = DMEM;
        rd_addr1_in = 5'd0;
        rd_addr2_in = 5'd0;

        // ---- Reset state, first write, asynchronous reset ----
        tick(); tick();
        chk("rst_wb_en", 64'(wb_en_out), 64'd0);
        chk("rst_wb_data", 64'(wb_data_out), 64'd0);
        chk("rst_fcnt", 64'(fault_cnt_out), 64'd0);
        chk("rst_instret", 64'(instret_out), 64'd0);
        reset = 1'b1;
        drive(mk(3'd0, OP_ALU), 32'h0, 32'hDEADBEEF, 5'd5, 1'b1);
        tick();
        chk("x5_wb_en", 64'(wb_en_out), 64'd1);
        chk("x5_wb_reg", 64'(wb_reg_out), 64'd5);
        chk("x5_wb_data", 64'(wb_data_out), 64'hDEADBEEF);
        drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        rd_addr1_in = 5'd5;
        #1;
        chk("x5_read", 64'(rs1_data_out), 64'hDEADBEEF);
        reset = 1'b0;
        #1;
        chk("arst_x5", 64'(rs1_data_out), 64'd0);
        chk("arst_wb_en", 64'(wb_en_out), 64'd0);
        chk("arst_wb_reg", 64'(wb_reg_out), 64'd0);
        chk("arst_wb_data", 64'(wb_data_out), 64'd0);
        chk("arst_instret", 64'(instret_out), 64'd0);
        tick();
        reset = 1'b1;

        // ---- Vector table: dmem word 0x80FF7F01 for every load ----
        vt[0]  = v(mk(3'd0, OP_ALU),  32'h0,        32'hDEADBEEF, 5'd5,  1, 1, 32'hDEADBEEF, 0, 1);
        vt[1]  = v(mk(F3_LB,  OP_LOAD), 32'h0,      32'h00002003, 5'd10, 1, 1, 32'hFFFFFF80, 0, 1);
        vt[2]  = v(mk(F3_LBU, OP_LOAD), 32'h0,      32'h00002003, 5'd11, 1, 1, 32'h00000080, 0, 1);
        vt[3]  = v(mk(F3_LH,  OP_LOAD), 32'h0,      32'h00002002, 5'd12, 1, 1, 32'hFFFF80FF, 0, 1);
        vt[4]  = v(mk(F3_LHU, OP_LOAD), 32'h0,      32'h00002000, 5'd13, 1, 1, 32'h00007F01, 0, 1);
        vt[5]  = v(mk(F3_LW,  OP_LOAD), 32'h0,      32'h00002000, 5'd14, 1, 1, 32'h80FF7F01, 0, 1);
        vt[6]  = v(mk(F3_LB,  OP_LOAD), 32'h0,      32'h00002001, 5'd15, 1, 1, 32'h0000007F, 0, 1);
        vt[7]  = v(mk(F3_LHU, OP_LOAD), 32'h0,      32'h00002003, 5'd16, 1, 0, 32'h0,        1, 0);
        vt[8]  = v(mk(F3_LW,  OP_LOAD), 32'h0,      32'h00001002, 5'd17, 1, 0, 32'h0,        1, 0);
        vt[9]  = v(mk(3'b011, OP_LOAD), 32'h0,      32'h00002000, 5'd18, 1, 0, 32'h0,        1, 0);
        vt[10] = v(mk(3'd0, OP_JAL),  32'hFFFFFFFC, 32'h00000055, 5'd1,  1, 1, 32'h00000000, 0, 1);
        vt[11] = v(mk(3'd0, OP_JALR), 32'h00000100, 32'h00000999, 5'd2,  1, 1, 32'h00000104, 0, 1);
        vt[12] = v(mk(3'd0, OP_ALU),  32'h0,        32'h00000077, 5'd0,  1, 0, 32'h00000077, 0, 1);
        vt[13] = v(mk(3'd0, OP_ALU),  32'h0,        32'h00000088, 5'd3,  0, 0, 32'h00000088, 0, 1);
        vt[14] = v(mk(3'b110, OP_LOAD), 32'h0,      32'h00002000, 5'd19, 0, 0, 32'h0,        1, 0);
        vt[15] = v(32'h0,             32'h0,        32'h00000099, 5'd20, 0, 0, 32'h00000099, 0, 1);

        m_fcnt = '0;
        m_ret  = '0;
        for (int i = 0; i < NV; i++) begin
            drive(vt[i].iw, vt[i].pc, vt[i].alu, vt[i].rd, vt[i].en);
            tick();
            if (vt[i].exp_fault) m_fcnt = m_fcnt + 1'b1;
            if (vt[i].iw != 32'h0) m_ret = m_ret + 1'b1;
            chk($sformatf("v%0d_wb_en", i), 64'(wb_en_out), 64'(vt[i].exp_en));
            chk($sformatf("v%0d_wb_reg", i), 64'(wb_reg_out), 64'(vt[i].rd));
            chk($sformatf("v%0d_fault", i), 64'(load_fault_out), 64'(vt[i].exp_fault));
            chk($sformatf("v%0d_fcnt", i), 64'(fault_cnt_out), 64'(m_fcnt));
            chk($sformatf("v%0d_instret", i), 64'(instret_out), 64'(m_ret));
            if (vt[i].chk_data)
                chk($sformatf("v%0d_wb_data", i), 64'(wb_data_out), 64'(vt[i].exp_data));
        end

        // Stored contents: committed values present, faulted/disabled targets untouched.
        drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        for (int i = 0; i < NV; i++) begin
            rd_addr1_in = vt[i].rd;
            rd_addr2_in = vt[i].rd;
            #1;
            chk($sformatf("v%0d_rf1", i), 64'(rs1_data_out), vt[i].exp_en ? 64'(vt[i].exp_data) : 64'd0);
            chk($sformatf("v%0d_rf2", i), 64'(rs2_data_out), vt[i].exp_en ? 64'(vt[i].exp_data) : 64'd0);
        end

        // ---- Bypass on both ports, then x0 write ----
        drive(mk(3'd0, OP_ALU), 32'h0, 32'h00001234, 5'd9, 1'b1);
        rd_addr1_in = 5'd9;
        rd_addr2_in = 5'd9;
        #1;
        chk("byp_rs1", 64'(rs1_data_out), 64'h1234);
        chk("byp_rs2", 64'(rs2_data_out), 64'h1234);
        tick();
        chk("byp_wb_en", 64'(wb_en_out), 64'd1);
        drive(mk(3'd0, OP_ALU), 32'h0, 32'h00005555, 5'd0, 1'b1);
        rd_addr1_in = 5'd0;
        #1;
        chk("x0_read", 64'(rs1_data_out), 64'd0);
        chk("x9_held", 64'(rs2_data_out), 64'h1234);
        tick();
        chk("x0_wb_en", 64'(wb_en_out), 64'd0);

        // ---- Fault pulse and saturation ----
        do_reset();
        drive(mk(F3_LW, OP_LOAD), 32'h0, 32'h00001002, 5'd7, 1'b1);
        tick();
        chk("sat_pulse", 64'(load_fault_out), 64'd1);
        chk("sat_cnt1", 64'(fault_cnt_out), 64'd1);
        chk("sat_no_wr", 64'(wb_en_out), 64'd0);
        drive(mk(3'd0, OP_ALU), 32'h0, 32'h0, 5'd0, 1'b0);
        tick();
        chk("sat_pulse_end", 64'(load_fault_out), 64'd0);
        chk("sat_cnt_hold", 64'(fault_cnt_out), 64'd1);
        drive(mk(F3_LW, OP_LOAD), 32'h0, 32'h00001002, 5'd7, 1'b1);
        for (int i = 0; i < 259; i++) tick();
        chk("sat_cnt255", 64'(fault_cnt_out), 64'd255);
        drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        rd_addr1_in = 5'd7;
        #1;
        chk("sat_x7", 64'(rs1_data_out), 64'd0);

        // ---- instret: bubbles skipped, then wrap ----
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i == 1 || i == 3 || i == 6)
                drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
            else
                drive(mk(3'd0, OP_ALU), 32'h0, 32'h0, 5'd4, 1'b0);
            tick();
        end
        chk("ret_5", 64'(instret_out), 64'd5);
        drive(mk(3'd0, OP_ALU), 32'h0, 32'h0, 5'd4, 1'b0);
        for (int i = 0; i < 1018; i++) tick();
        chk("ret_max", 64'(instret_out), 64'd1023);
        tick();
        chk("ret_wrap", 64'(instret_out), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rv32i_wb_stage.md
Name: rv32i_wb_stage

Overview:
Writeback stage of the 5-stage RV32I pipeline. Sits directly downstream of the MEM-stage pipeline register and consumes its registered outputs, plus the synchronous data-memory read word for the same instruction. Selects and aligns the writeback value, then commits it to the architectural register file that this block owns. Provides register-file read ports and forwarding values to the decode stage, and keeps a retired-instruction counter.

Parameters:
NREGS, 32, number of architectural registers; x0 is hardwired to zero.
INSTRET_W, 64, width of the retired-instruction counter.
FCNT_W, 8, width of the saturating load-fault counter.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
wb_en_in  in  1  writeback enable from MEM stage
pc_in  in  32  PC of the instruction in WB
iw_in  in  32  instruction word; 32'h0 encodes a bubble
alu_in  in  32  ALU result; effective address for loads
wb_reg_in  in  5  destination register index
dmem_rdata_in  in  32  data-memory read word at address {alu_in[31:2],2'b00}, valid this cycle
rd_addr1_in  in  5  decode read-port-1 index
rd_addr2_in  in  5  decode read-port-2 index
rs1_data_out  out  32  read-port-1 data, combinational
rs2_data_out  out  32  read-port-2 data, combinational
wb_en_out  out  1  registered: a write committed last cycle
wb_reg_out  out  5  registered: destination of that write
wb_data_out  out  32  registered: value of that write
load_fault_out  out  1  registered one-cycle pulse on a faulting load
fault_cnt_out  out  FCNT_W  saturating count of faulting loads
instret_out  out  INSTRET_W  count of retired non-bubble instructions

Behaviour:
- Reset (reset==0, asynchronous):
  - All registers x0..x31 clear to 0.
  - wb_en_out, wb_reg_out, wb_data_out, load_fault_out, fault_cnt_out and instret_out clear to 0.
  - The block holds this state while reset is low and resumes on the first rising clk edge after reset goes high.
- Decode:
  - opcode = iw_in[6:0]; funct3 = iw_in[14:12]; off = alu_in[1:0].
- Writeback value selection:
  - LOAD (7'b0000011): aligned load data.
  - JAL (7'b1101111) or JALR (7'b1100111): pc_in + 32'd4, modulo 2^32.
  - All other opcodes: alu_in.
- Load alignment:
  - LB (000): dmem_rdata_in byte [8*off+7 : 8*off], sign-extended.
  - LBU (100): same byte, zero-extended.
  - LH (001): halfword selected by off[1], sign-extended.
  - LHU (101): same halfword, zero-extended.
  - LW (010): the full word.
- Faulting loads:
  - A load faults if it is LH/LHU with off[0]=1, LW with off!=0, or funct3 is 011, 110 or 111.
  - A faulting load commits no write.
  - load_fault_out is 1 in the next cycle only.
  - fault_cnt_out increments and saturates at all-ones.
  - Faults are evaluated only when opcode is LOAD, independent of wb_en_in.
- Commit:
  - commit = wb_en_in && wb_reg_in!=0 && !fault.
  - On a rising edge with commit set, regfile[wb_reg_in] <= wb value.
  - wb_en_out <= commit; wb_reg_out <= wb_reg_in; wb_data_out <= wb value.
  - wb_data_out and wb_reg_out update every cycle; consumers qualify them with wb_en_out.
  - A write to x0 is discarded and wb_en_out is 0.
- Read ports (combinational):
  - An index of 0 reads 0.
  - If the index equals wb_reg_in and commit is 1 in the same cycle, the port returns the in-flight wb value (write-through bypass).
  - Otherwise the port returns the stored register.
  - The two ports are independent, and both may bypass simultaneously.
- instret_out:
  - Increments by 1 on each edge where iw_in != 0, including faulting instructions.
  - Wraps modulo 2^INSTRET_W.
- Latency: one cycle from inputs to registered outputs; zero cycles to the read ports via bypass.
- No stall or flush inputs: the stage accepts one instruction per cycle unconditionally.

Decomposition:
- Shared package rv32i_pkg:
  - Opcode constants OP_LOAD, OP_JAL, OP_JALR.
  - Load funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
- Sub-module rv32i_regfile:
  - NREGS x 32 storage.
  - One write port; two combinational read ports with x0 forcing and write-through bypass.
  - Asynchronous active-low clear.
- rv32i_wb_stage keeps the select/align logic, fault detection, counters and output registers.

Test Plan:
1. Reset, then write 0xDEADBEEF to x5 (ALU op) -> next cycle wb_en_out=1, wb_reg_out=5, wb_data_out=0xDEADBEEF; rd_addr1_in=5 reads 0xDEADBEEF; assert reset low -> x5 reads 0 and all outputs are 0 immediately.
2. dmem_rdata_in=0x80FF7F01, LB off=3 -> 0xFFFFFF80; LBU off=3 -> 0x00000080; LH off=2 -> 0xFFFF80FF; LHU off=0 -> 0x00007F01; LW off=0 -> 0x80FF7F01.
3. LW with alu_in=0x1002, wb_en_in=1, rd=7 -> no write to x7, load_fault_out pulses for 1 cycle, fault_cnt_out=1; repeat 260 times -> fault_cnt_out saturates at 255.
4. JAL with pc_in=0xFFFFFFFC, rd=1 -> x1=0x00000000 (wrap); JALR with pc_in=0x100 -> rd gets 0x104.
5. Write x9=0x1234 with rd_addr1_in=rd_addr2_in=9 in the same cycle -> both read ports return 0x1234 before the edge; write to x0 -> x0 reads 0 and wb_en_out=0.
6. Five instructions interleaved with three iw_in=0 bubbles -> instret_out=5; preload instret_out to all-ones via a long run and confirm it wraps to 0.
